// File: rtl/ac1_acc_reg.sv
// ---------------------------------------------------------------------------
// ac1_acc_reg
//
// Accumulation register and beat controller for the first accumulator (AC1).
// The register holds the running partial sum and feeds it straight back to the
// AC1 adder as its shift-register operand. Each valid beat from the adder is
// captured. After NB = M/P beats the sum is offered to the AC2 stage over a
// valid/ready handshake.
//
// Parameters:
//   M  total bits accumulated per result (power of two)
//   P  bits per beat from the bit-adder (power of two, P <= M)
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a new accumulation (IDLE, or HOLD with result_ready)
//   flush          synchronous abort back to IDLE, clears the register
//   in_valid       a beat is present on in_from_adder
//   in_from_adder  adder output (bit count plus current register value)
//   out_to_adder   current register value, operand back to the adder
//   busy           high while accumulating or holding a result
//   result         final sum, meaningful while result_valid is high
//   result_valid   result offered to AC2
//   result_ready   AC2 accepts the result
//   ovf_err        (only with AC1_ACC_OVF_CHK_EN) sticky illegal-operand flag
//
// Optional feature macro: AC1_ACC_OVF_CHK_EN
//   When defined, adds the ovf_err output. It goes high when a captured value
//   exceeds M or is smaller than the current register value. The flag clears
//   only on reset or flush.
// ---------------------------------------------------------------------------
module ac1_acc_reg #(
  parameter int M = 16,
  parameter int P = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [$clog2(M):0]   in_from_adder,
  output logic [$clog2(M):0]   out_to_adder,
  output logic                 busy,
  output logic [$clog2(M):0]   result,
  output logic                 result_valid,
`ifdef AC1_ACC_OVF_CHK_EN
  output logic                 ovf_err,
`endif
  input  logic                 result_ready
);

  localparam int W  = $clog2(M) + 1;
  localparam int NB = M / P;
  // A one-beat configuration still needs a legal (1-bit) counter.
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          capture;

  // State, partial sum and beat counter. All three clear together on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. flush overrides everything else. HOLD keeps acc_q
  // frozen until AC2 takes the result. A start seen on the accepting cycle
  // goes straight back to ACC, so back-to-back results have no bubble.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        ACC: begin
          if (in_valid) begin
            capture = 1'b1;
            acc_d   = in_from_adder;
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            if (start) begin
              state_d = ACC;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The outputs depend only on registers. No input reaches them
  // combinationally, so the adder feedback loop is never closed through
  // this block.
  assign out_to_adder = acc_q;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == HOLD);
  assign result       = (state_q == HOLD) ? acc_q : '0;

`ifdef AC1_ACC_OVF_CHK_EN
  logic ovf_q, ovf_d;

  // Sticky error flag. A capture above M, or one below the running sum,
  // means the adder wrapped or was fed an illegal operand.
  always_comb begin
    ovf_d = ovf_q;
    if (flush) begin
      ovf_d = 1'b0;
    end else if (capture && ((in_from_adder > W'(M)) || (in_from_adder < acc_q))) begin
      ovf_d = 1'b1;
    end
  end

  // Register for the sticky flag. Only reset or flush clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;
`else
  // Without the error checker, the capture strobe has no consumer.
  logic unusedCapture;
  assign unusedCapture = capture;
`endif

endmodule

// File: doc/ac1_acc_reg.md
Name: ac1_acc_reg

Overview:
- Accumulation register and beat controller for the first accumulator (AC1).
- Holds the running partial sum and feeds it back to the AC1 adder as its shift-register operand.
- Captures the adder output on each valid beat and counts beats until M bits (M/P beats of P bits each) are accumulated.
- Presents the final sum to the downstream AC2 stage over a valid/ready handshake.

Parameters:
- M, 16, total bits accumulated per result (power of two).
- P, 4, bits per beat from the bit-adder (power of two, P <= M); beats per result NB = M/P.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new accumulation; sampled in IDLE, and in HOLD on a completing handshake.
- flush  in  1  synchronous abort; returns to IDLE and clears the register.
- in_valid  in  1  a beat is present on in_from_adder this cycle.
- in_from_adder  in  $clog2(M)+1  AC1 adder output (bit-adder count plus current register value).
- out_to_adder  out  $clog2(M)+1  current register value, wired to the adder's shift-register operand.
- busy  out  1  high in ACC and HOLD.
- result  out  $clog2(M)+1  final sum, valid while result_valid is high.
- result_valid  out  1  result available to AC2.
- result_ready  in  1  AC2 accepts result.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; acc_q = 0; beat counter = 0.
  - out_to_adder = 0, result = 0, result_valid = 0, busy = 0.
- out_to_adder = acc_q at all times (registered, no combinational path from inputs).
- IDLE:
  - in_valid is ignored.
  - start=1 → acc_q <= 0, cnt <= 0, go to ACC on the next edge.
- ACC, on each cycle with in_valid=1:
  - acc_q <= in_from_adder.
  - If cnt == NB-1: cnt <= 0, go to HOLD.
  - Otherwise cnt <= cnt+1.
  - in_valid=0 cycles are stalls: acc_q and cnt hold.
  - start is ignored in ACC.
- HOLD:
  - result_valid=1; result = acc_q; acc_q is frozen; in_valid is ignored.
  - result_ready=1 and start=0 → IDLE the next cycle.
  - result_ready=1 and start=1 (same cycle) → acc_q <= 0, cnt <= 0, go straight to ACC (back-to-back, no bubble).
  - result_ready=0 → stay in HOLD; result stays stable.
- Latency:
  - First beat is captured one edge after start.
  - result_valid rises on the edge that captures beat NB-1.
- Arithmetic: width $clog2(M)+1 holds 0..M; the module performs no addition itself.
- flush:
  - Highest synchronous priority in any state, including mid-ACC and in HOLD with result_valid=1.
  - Next edge: IDLE, acc_q=0, cnt=0, result_valid=0.
  - A pending result is dropped.
- Asynchronous reset mid-operation behaves identically to flush, but takes effect immediately.
- NB=1 (P=M): every valid beat in ACC completes a result.

Optional Feature:
- Macro: AC1_ACC_OVF_CHK_EN.
- With the macro defined:
  - Adds output port ovf_err (1 bit), reset 0.
  - ovf_err is sticky high if, on any ACC capture, in_from_adder > M or in_from_adder < acc_q (wrap or illegal operand).
  - ovf_err clears only on rst_n or flush.
- Without the macro: the port and its logic are absent; capture behaviour is identical.

Test Plan:
- M=16, P=4: after reset, check outputs → out_to_adder=0, result_valid=0, busy=0; then start, drive in_from_adder = 3, 7, 9, 12 on 4 consecutive valid beats → result_valid=1 with result=12 on the 4th capture edge; out_to_adder tracks 3, 7, 9, 12.
- Stall mid-accumulation: beats 2, 5, in_valid=0 for 3 cycles, then 6, 10 → cnt and acc_q hold during the stall; result=10.
- Backpressure: result_ready=0 for 5 cycles in HOLD while in_valid toggles with junk data → result stays 12, acc_q unchanged; a new start without result_ready is ignored.
- Back-to-back: result_ready=1 and start=1 in the same cycle → next cycle in ACC with out_to_adder=0, result_valid=0, busy stays 1.
- flush after 2 of 4 beats (acc_q=5) → next cycle IDLE, out_to_adder=0; a later full run of 4 beats produces its correct result. Repeat with rst_n low in HOLD → immediate clear, no clock edge needed.
- With AC1_ACC_OVF_CHK_EN: drive 17 on a beat → ovf_err=1 and stays 1 until flush; drive 4 after acc_q=6 → ovf_err set; legal run → ovf_err stays 0.
